// File: rtl/cpu_datapath.sv
// Datapath for the simple 16-bit CPU: IR/decoder, 8x16 register file, A/B/C
// pipeline registers, shifter, ALU and Z/N/V status, all strobed by the control FSM.
module cpu_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        load_ir,
  input  logic [2:0]  nsel,
  input  logic [3:0]  vsel,
  input  logic        write,
  input  logic        loada,
  input  logic        loadb,
  input  logic        loadc,
  input  logic        loads,
  input  logic        asel,
  input  logic        bsel,
  input  logic [15:0] mdata,
  input  logic [7:0]  pc,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [15:0] datapath_out,
  output logic        Z_out,
  output logic        N_out,
  output logic        V_out
);

  logic [15:0] ir_q;
  logic [15:0] rf_q [8];
  logic [15:0] a_q, b_q, c_q;
  logic        z_q, n_q, v_q;

  logic [2:0]  rn, rd, rm, reg_idx;
  logic [1:0]  shift;
  logic [15:0] sximm8, sximm5;
  logic [15:0] rd_data, wb_data, sh_out, alu_a, alu_b, alu_d;
  logic        v_d;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign shift  = ir_q[4:3];
  assign rm     = ir_q[2:0];
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
  assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

  // One index serves both read and write, so nsel=000 falls through to R0.
  assign reg_idx = (rn & {3{nsel[0]}}) | (rm & {3{nsel[1]}}) | (rd & {3{nsel[2]}});
  assign rd_data = rf_q[reg_idx];

  always_comb begin
    wb_data = 16'h0000;
    if (vsel[3])      wb_data = c_q;
    else if (vsel[2]) wb_data = mdata;
    else if (vsel[1]) wb_data = sximm8;
    else if (vsel[0]) wb_data = {8'h00, pc};
  end

  always_comb begin
    sh_out = b_q;
    case (shift)
      2'b01:   sh_out = {b_q[14:0], 1'b0};
      2'b10:   sh_out = {1'b0, b_q[15:1]};
      2'b11:   sh_out = {b_q[15], b_q[15:1]};
      default: sh_out = b_q;
    endcase
  end

  assign alu_a = asel ? 16'h0000 : a_q;
  assign alu_b = bsel ? sximm5 : sh_out;

  // Overflow: operands' effective signs agree but the result's sign differs.
  always_comb begin
    alu_d = 16'h0000;
    v_d   = 1'b0;
    case (op)
      2'b00: begin
        alu_d = alu_a + alu_b;
        v_d   = (alu_a[15] == alu_b[15]) && (alu_d[15] != alu_a[15]);
      end
      2'b01: begin
        alu_d = alu_a - alu_b;
        v_d   = (alu_a[15] != alu_b[15]) && (alu_d[15] != alu_a[15]);
      end
      2'b10:   alu_d = alu_a & alu_b;
      default: alu_d = ~alu_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= 16'h0000;
    end else if (write) begin
      rf_q[reg_idx] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q <= 16'h0000;
      a_q  <= 16'h0000;
      b_q  <= 16'h0000;
      c_q  <= 16'h0000;
      z_q  <= 1'b0;
      n_q  <= 1'b0;
      v_q  <= 1'b0;
    end else begin
      if (load_ir) ir_q <= instr;
      if (loada)   a_q  <= rd_data;
      if (loadb)   b_q  <= rd_data;
      if (loadc)   c_q  <= alu_d;
      if (loads) begin
        z_q <= (alu_d == 16'h0000);
        n_q <= alu_d[15];
        v_q <= v_d;
      end
    end
  end

  assign datapath_out = c_q;
  assign Z_out        = z_q;
  assign N_out        = n_q;
  assign V_out        = v_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: table of ALU vectors plus hand-written instruction
// sequences, with expected values queued and compared as outputs appear.
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        load_ir;
  logic [2:0]  nsel;
  logic [3:0]  vsel;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic [15:0] mdata;
  logic [7:0]  pc;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [15:0] datapath_out;
  logic        Z_out, N_out, V_out;

  always #5 clk = ~clk;

  cpu_datapath dut (
    .clk(clk), .reset(reset), .instr(instr), .load_ir(load_ir),
    .nsel(nsel), .vsel(vsel), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .mdata(mdata), .pc(pc),
    .opcode(opcode), .op(op), .datapath_out(datapath_out),
    .Z_out(Z_out), .N_out(N_out), .V_out(V_out)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [1:0]  alu_op;
    logic [1:0]  sh;
    logic        as;
    logic        bs;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_c;
    logic [2:0]  exp_znv;
  } vec_t;
  vec_t vecs[10];

  task automatic push_exp(input string name, input logic [15:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [15:0] act);
    sb_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty got=%h", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.name, act, e.exp);
      end else begin
        $display("ok   %s got=%h", e.name, act);
      end
    end
  endtask

  function automatic logic [15:0] flags();
    return {13'b0, Z_out, N_out, V_out};
  endfunction

  function automatic logic [15:0] dec();
    return {11'b0, opcode, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    load_ir = 0; write = 0; loada = 0; loadb = 0; loadc = 0; loads = 0;
    asel = 0; bsel = 0; nsel = 3'b000; vsel = 4'b0000;
  endtask

  task automatic ld_ir(input logic [15:0] w);
    instr = w; load_ir = 1; tick(); load_ir = 0;
  endtask

  task automatic wr(input logic [2:0] n, input logic [3:0] v, input logic [15:0] md);
    nsel = n; vsel = v; mdata = md; write = 1; tick(); write = 0;
  endtask

  task automatic ld_a(input logic [2:0] n);
    nsel = n; loada = 1; tick(); loada = 0;
  endtask

  task automatic ld_b(input logic [2:0] n);
    nsel = n; loadb = 1; tick(); loadb = 0;
  endtask

  task automatic ld_c(input logic as, input logic bs, input logic s);
    asel = as; bsel = bs; loadc = 1; loads = s; tick();
    loadc = 0; loads = 0; asel = 0; bsel = 0;
  endtask

  // Reads R[idx] through the datapath: C = 0 + R[idx] via an ADD with Rm=idx.
  task automatic read_reg(input logic [2:0] idx, input string name, input logic [15:0] exp);
    logic [15:0] w;
    w = {3'b101, 2'b00, 3'b000, 3'b000, 2'b00, idx};
    ld_ir(w);
    ld_b(3'b010);
    push_exp(name, exp);
    ld_c(1'b1, 1'b0, 1'b0);
    pop_check(datapath_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{2'b00, 2'b00, 1'b0, 1'b0, 16'h0003, 16'h0004, 16'h0007, 3'b000};
    vecs[1] = '{2'b00, 2'b00, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 3'b011};
    vecs[2] = '{2'b01, 2'b00, 1'b0, 1'b0, 16'h0005, 16'h0005, 16'h0000, 3'b100};
    vecs[3] = '{2'b10, 2'b00, 1'b0, 1'b0, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b000};
    vecs[4] = '{2'b11, 2'b00, 1'b0, 1'b0, 16'h1234, 16'h00FF, 16'hFF00, 3'b010};
    vecs[5] = '{2'b00, 2'b10, 1'b0, 1'b0, 16'h0001, 16'h8001, 16'h4001, 3'b000};
    vecs[6] = '{2'b00, 2'b11, 1'b0, 1'b0, 16'h0000, 16'h8001, 16'hC000, 3'b010};
    vecs[7] = '{2'b01, 2'b00, 1'b1, 1'b0, 16'h1234, 16'h8000, 16'h8000, 3'b011};
    vecs[8] = '{2'b00, 2'b10, 1'b0, 1'b1, 16'h0010, 16'h5555, 16'h0002, 3'b000};
    vecs[9] = '{2'b10, 2'b01, 1'b0, 1'b0, 16'hFFFF, 16'h4001, 16'h8002, 3'b010};

    clear_strobes();
    instr = 16'h0000; mdata = 16'h0000; pc = 8'h00;
    reset = 1;
    tick(); tick();
    reset = 0;

    push_exp("reset_out", 16'h0000);   pop_check(datapath_out);
    push_exp("reset_flags", 16'h0000); pop_check(flags());
    push_exp("reset_decode", 16'h0000); pop_check(dec());
    // IR=0 decodes as ADD with shift 00: C = A + B, so a zero proves both cleared.
    push_exp("reset_a_plus_b", 16'h0000);
    ld_c(1'b0, 1'b0, 1'b1);
    pop_check(datapath_out);

    // MOV R0,#7 ; MOV R1,#-2
    push_exp("mov_decode", {11'b0, 3'b110, 2'b10});
    ld_ir(16'hD007);
    pop_check(dec());
    wr(3'b001, 4'b0010, 16'h0000);
    ld_ir(16'hD1FE);
    wr(3'b001, 4'b0010, 16'h0000);
    read_reg(3'd0, "mov_r0", 16'h0007);
    read_reg(3'd1, "mov_r1", 16'hFFFE);

    // ADD R2,R1,R0 LSL#1
    ld_ir(16'hA148);
    ld_a(3'b001);
    ld_b(3'b010);
    push_exp("add_out", 16'h000C);
    ld_c(1'b0, 1'b0, 1'b0);
    pop_check(datapath_out);
    wr(3'b100, 4'b1000, 16'h0000);
    read_reg(3'd2, "add_r2", 16'h000C);

    // CMP R1,R0
    ld_ir(16'hA900);
    ld_a(3'b001);
    ld_b(3'b010);
    push_exp("cmp_out", 16'hFFF7);
    push_exp("cmp_flags", 16'h0002);
    ld_c(1'b0, 1'b0, 1'b1);
    pop_check(datapath_out);
    pop_check(flags());

    // Signed overflow: 0x8000 - 1
    ld_ir(16'hAC05);
    wr(3'b001, 4'b0100, 16'h8000);
    ld_ir(16'hD501);
    wr(3'b001, 4'b0010, 16'h0000);
    ld_ir(16'hAC05);
    ld_a(3'b001);
    ld_b(3'b010);
    push_exp("ovf_out", 16'h7FFF);
    push_exp("ovf_flags", 16'h0001);
    ld_c(1'b0, 1'b0, 1'b1);
    pop_check(datapath_out);
    pop_check(flags());

    // MVN R6,R2 ASR
    ld_ir(16'hB8DA);
    ld_b(3'b010);
    push_exp("mvn_out", 16'hFFF9);
    ld_c(1'b0, 1'b0, 1'b0);
    pop_check(datapath_out);
    wr(3'b100, 4'b1000, 16'h0000);
    read_reg(3'd6, "mvn_r6", 16'hFFF9);

    // Read-during-write on R0: A takes old 7, B next cycle takes new 0x1234.
    ld_ir(16'hA000);
    nsel = 3'b001; vsel = 4'b0100; mdata = 16'h1234; write = 1; loada = 1;
    tick();
    write = 0; loada = 0;
    ld_b(3'b001);
    push_exp("rdw_old_plus_new", 16'h123B);
    ld_c(1'b0, 1'b0, 1'b0);
    pop_check(datapath_out);

    // writeback from pc when only vsel[0] set
    ld_ir(16'hD300);
    pc = 8'hA5;
    wr(3'b001, 4'b0001, 16'h0000);
    read_reg(3'd3, "wb_pc_r3", 16'h00A5);

    for (int i = 0; i < 10; i++) begin
      logic [15:0] w;
      w = {3'b101, vecs[i].alu_op, 3'd1, 3'd3, vecs[i].sh, 3'd2};
      push_exp($sformatf("vec%0d_decode", i), {11'b0, 3'b101, vecs[i].alu_op});
      ld_ir(w);
      pop_check(dec());
      wr(3'b001, 4'b0100, vecs[i].a);
      wr(3'b010, 4'b0100, vecs[i].b);
      ld_a(3'b001);
      ld_b(3'b010);
      push_exp($sformatf("vec%0d_out", i), vecs[i].exp_c);
      push_exp($sformatf("vec%0d_flags", i), {13'b0, vecs[i].exp_znv});
      ld_c(vecs[i].as, vecs[i].bs, 1'b1);
      pop_check(datapath_out);
      pop_check(flags());
    end

    // Reset mid-instruction with every enable asserted.
    ld_ir(16'hA148);
    ld_a(3'b001);
    ld_b(3'b010);
    reset = 1; loada = 1; loadb = 1; loadc = 1; loads = 1; load_ir = 1;
    instr = 16'hFFFF; write = 1; nsel = 3'b100; vsel = 4'b1000;
    tick();
    reset = 0;
    clear_strobes();
    push_exp("mreset_out", 16'h0000);    pop_check(datapath_out);
    push_exp("mreset_flags", 16'h0000);  pop_check(flags());
    push_exp("mreset_decode", 16'h0000); pop_check(dec());
    push_exp("mreset_a_plus_b", 16'h0000);
    ld_c(1'b0, 1'b0, 1'b1);
    pop_check(datapath_out);
    for (int r = 0; r < 8; r++) begin
      read_reg(3'(r), $sformatf("mreset_r%0d", r), 16'h0000);
    end
    ld_ir(16'hD007);
    wr(3'b001, 4'b0010, 16'h0000);
    read_reg(3'd0, "post_reset_mov_r0", 16'h0007);

    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

- Datapath plus instruction register/decoder driven by the instruction-control FSM.
- Latches a 16-bit instruction and hands `opcode`/`op` to the FSM.
- Holds the 8×16 register file, A/B/C pipeline registers, shifter, ALU and Z/N/V status register.
- Executes register moves, immediate moves and ALU operations under the FSM's per-cycle control strobes.

## Interface
- Parameters: none (16-bit data, 8 registers fixed).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; clock `clk`.
- `instr`  in  16  instruction word, captured when `load_ir`=1.
- `load_ir`  in  1  instruction register load enable.
- `nsel`  in  3  register select: bit0=Rn, bit1=Rm, bit2=Rd.
- `vsel`  in  4  writeback select: bit3=C, bit2=`mdata`, bit1=sximm8, bit0={8'h00,`pc`}.
- `write`  in  1  register file write enable.
- `loada`, `loadb`, `loadc`, `loads`  in  1 each  A/B/C/status register enables.
- `asel`  in  1  1: ALU A input = 16'h0000; 0: A register.
- `bsel`  in  1  1: ALU B input = sximm5; 0: shifter output.
- `mdata`  in  16  external write data.
- `pc`  in  8  program counter value.
- `opcode`  out  3  IR[15:13], to FSM.
- `op`  out  2  IR[12:11], to FSM.
- `datapath_out`  out  16  C register.
- `Z_out`, `N_out`, `V_out`  out  1 each  status register.

## Operation
- IR fields:
  - opcode [15:13], op [12:11], Rn [10:8], Rd [7:5], shift [4:3], Rm [2:0].
  - imm8 [7:0] → sximm8 (sign-extended to 16).
  - imm5 [4:0] → sximm5 (sign-extended to 16).
- Register index: (Rn & {3{nsel[0]}}) | (Rm & {3{nsel[1]}}) | (Rd & {3{nsel[2]}}).
  - Shared by read and write; nsel=000 selects R0.
- Register read is combinational from the index.
- Register write is synchronous: R[index] ← writeback value when `write`=1.
- Writeback value: highest set `vsel` bit wins (3>2>1>0); `vsel`=0000 writes 16'h0000.
- Shifter operates on the B register, selected by IR shift:
  - 00: pass-through.
  - 01: <<1, zero fill.
  - 10: >>1 logical.
  - 11: >>1 arithmetic (MSB replicated).
- ALU operation selected by `op`:
  - 00: A+B.
  - 01: A−B.
  - 10: A&B.
  - 11: ~B.
  - Result is 16 bits, carry discarded.
- Flags, computed from the ALU result:
  - Z = (result==0).
  - N = result[15].
  - V = signed overflow for op 00/01; V=0 for op 10/11.
- Registered updates at the clock edge:
  - A ← R[index] when `loada`=1.
  - B ← R[index] when `loadb`=1.
  - C ← ALU result when `loadc`=1.
  - {Z,N,V} ← flags when `loads`=1.
- All enables are independent. Simultaneous assertion is legal and each target updates from pre-edge values.

## Timing
- Reset (synchronous, highest priority) clears to 0: R0–R7, IR, A, B, C, status.
  - Post-reset outputs: `datapath_out`=0, Z/N/V=0, `opcode`=000, `op`=00.
- `opcode`/`op` are valid the cycle after the `load_ir` edge. Decode in that cycle uses the pre-edge IR.
- Read-during-write to the same register:
  - The combinational read and any A/B load return the old value.
  - The new value is visible the next cycle.
- ALU path latency: A/B load edge → C load on the next edge → `datapath_out` valid after that edge.
- `write` with `vsel[3]` writes the current C, so C is loaded at least one edge earlier.
- Reset asserted mid-instruction overrides all enables that cycle; no partial update survives.
- No stall or handshake: every enable is a single-cycle strobe, and holding an enable reloads every cycle.

## Test plan
- MOV R0,#7: `instr`=0xD007, `load_ir` pulse, then `nsel`=001, `vsel`=0010, `write`=1 → R0=0x0007. Then MOV R1,#−2: `instr`=0xD1FE, same sequence → R1=0xFFFE.
- ADD R2,R1,R0 LSL#1: `instr`=0xA148; sequence below → `datapath_out`=0x000C, R2=0x000C.
  - `loada` with `nsel`=001.
  - `loadb` with `nsel`=010.
  - `loadc` with `asel`=0, `bsel`=0.
  - `write` with `nsel`=100, `vsel`=1000.
- CMP R1,R0: `instr`=0xA900; `loada`, `loadb`, then `loadc`+`loads` → C=0xFFF7, N=1, Z=0, V=0.
- Overflow, `instr`=0xAC05:
  - `nsel`=001, `vsel`=0100, `mdata`=0x8000, `write` → R4=0x8000.
  - MOV R5,#1 (`instr`=0xD501) → R5=1.
  - Reload 0xAC05, then `loada`/`loadb`/`loadc`+`loads` → C=0x7FFF, V=1, N=0, Z=0.
- MVN R6,R2 ASR: `instr`=0xB8DA; `loadb` (`nsel`=010), `loadc`, then `write` (`nsel`=100, `vsel`=1000) → R6=0xFFF9. Same-cycle `write` R0 plus `loada` R0 → A gets the old value.
- Assert `reset` with `loadc`=1 and `write`=1 → all R0–R7, A, B, C and status read 0, `datapath_out`=0x0000, next instruction executes normally.
